// File: rtl/gtplink_n.sv
// gtplink_n: multi-lane 16-bit transceiver link front end.
// Per lane: byte-alignment to the K28.5 comma, a DOWN/SYNC/UP link
// state machine with windowed error tolerance, a saturating error
// counter and an idle-inserting TX register.

module gtplink_lane #(
   parameter logic [7:0] COMMA     = 8'hBC,
   parameter logic [7:0] IDLE_HI   = 8'h50,
   parameter int         UP_COUNT  = 16,
   parameter int         ERR_LIMIT = 4,
   parameter int         WINDOW    = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        err_clr_i,
   input  logic [15:0] rx_data_i,
   input  logic [1:0]  rx_k_i,
   input  logic [1:0]  rx_e_i,
   input  logic [15:0] tx_data_i,
   input  logic        tx_valid_i,
   output logic [15:0] data_o,
   output logic        k_o,
   output logic        valid_o,
   output logic        up_o,
   output logic        is_up_o,
   output logic [15:0] err_cnt_o,
   output logic [15:0] tx_data_o,
   output logic [1:0]  tx_k_o
);
   localparam logic [1:0] ST_DOWN = 2'd0;
   localparam logic [1:0] ST_SYNC = 2'd1;
   localparam logic [1:0] ST_UP   = 2'd2;
   localparam int WW = $clog2(WINDOW);
   localparam logic [WW-1:0] WIN_ONE = WW'(1);
   localparam logic [7:0] UPC = 8'(UP_COUNT);
   localparam logic [7:0] ERL = 8'(ERR_LIMIT);

   logic [1:0]    state_q, state_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [WW-1:0] win_q, win_d;
   logic [7:0]    werr_q, werr_d;
   logic          swap_q, swap_d;
   logic [7:0]    prev_d_q;
   logic          prev_k_q, prev_e_q;
   logic [15:0]   data_q, errc_q, txd_q;
   logic          k_q, valid_q, up_q;
   logic [1:0]    txk_q;

   logic [15:0] al_d;
   logic [1:0]  al_k, al_e;
   logic        raw_lo_comma, raw_hi_comma, al_lo_comma, al_hi_comma, al_err;

   // Realign the word (and its K/error flags) using the held upper byte
   always_comb begin
      raw_lo_comma = rx_k_i[0] && (rx_data_i[7:0]  == COMMA);
      raw_hi_comma = rx_k_i[1] && (rx_data_i[15:8] == COMMA);
      al_d = swap_q ? {rx_data_i[7:0], prev_d_q} : rx_data_i;
      al_k = swap_q ? {rx_k_i[0], prev_k_q}      : rx_k_i;
      al_e = swap_q ? {rx_e_i[0], prev_e_q}      : rx_e_i;
      al_lo_comma = al_k[0] && (al_d[7:0]  == COMMA);
      al_hi_comma = al_k[1] && (al_d[15:8] == COMMA);
      // Once up, a comma in the upper byte means alignment was lost
      al_err = (|al_e) || ((state_q == ST_UP) && al_hi_comma);
   end

   // Link state machine, swap tracking and error-window bookkeeping
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      swap_d  = swap_q;
      win_d   = '0;
      werr_d  = '0;
      // Alignment may only move while the link is not yet up
      if (state_q != ST_UP) begin
         if (raw_lo_comma)      swap_d = 1'b0;
         else if (raw_hi_comma) swap_d = 1'b1;
      end
      case (state_q)
         ST_DOWN: begin
            cnt_d = '0;
            if (al_lo_comma) begin
               state_d = ST_SYNC;
               cnt_d   = 8'd1;
            end
         end
         ST_SYNC: begin
            if (al_err) begin
               state_d = ST_DOWN;
               cnt_d   = '0;
            end else if (al_lo_comma) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == UPC) state_d = ST_UP;
            end
         end
         ST_UP: begin
            win_d = win_q + WIN_ONE;
            // An error on the wrap cycle is the first of the new window
            werr_d = ((&win_q) ? 8'd0 : werr_q) + {7'd0, al_err};
            if (werr_d == ERL) begin
               state_d = ST_DOWN;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_DOWN;
            cnt_d   = '0;
         end
      endcase
   end

   // State, pipeline outputs, error counter and TX register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_DOWN;
         cnt_q    <= '0;
         win_q    <= '0;
         werr_q   <= '0;
         swap_q   <= 1'b0;
         prev_d_q <= '0;
         prev_k_q <= 1'b0;
         prev_e_q <= 1'b0;
         data_q   <= '0;
         k_q      <= 1'b0;
         valid_q  <= 1'b0;
         up_q     <= 1'b0;
         errc_q   <= '0;
         txd_q    <= {IDLE_HI, COMMA};
         txk_q    <= 2'b01;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         win_q    <= win_d;
         werr_q   <= werr_d;
         swap_q   <= swap_d;
         prev_d_q <= rx_data_i[15:8];
         prev_k_q <= rx_k_i[1];
         prev_e_q <= rx_e_i[1];
         data_q   <= al_d;
         k_q      <= |al_k;
         valid_q  <= (state_q == ST_UP) && !(|al_k);
         up_q     <= (state_q == ST_UP);
         if (err_clr_i)                errc_q <= '0;
         else if (al_err && !(&errc_q)) errc_q <= errc_q + 16'd1;
         txd_q <= tx_valid_i ? tx_data_i : {IDLE_HI, COMMA};
         txk_q <= tx_valid_i ? 2'b00 : 2'b01;
      end
   end

   assign data_o    = data_q;
   assign k_o       = k_q;
   assign valid_o   = valid_q;
   assign up_o      = up_q;
   assign is_up_o   = (state_q == ST_UP);
   assign err_cnt_o = errc_q;
   assign tx_data_o = txd_q;
   assign tx_k_o    = txk_q;
endmodule

module gtplink_n #(
   parameter int         NLANES    = 4,
   parameter logic [7:0] COMMA     = 8'hBC,
   parameter logic [7:0] IDLE_HI   = 8'h50,
   parameter int         UP_COUNT  = 16,
   parameter int         ERR_LIMIT = 4,
   parameter int         WINDOW    = 256
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [16*NLANES-1:0]   rx_data,
   input  logic [2*NLANES-1:0]    rx_charisk,
   input  logic [2*NLANES-1:0]    rx_err,
   output logic [16*NLANES-1:0]   data_o,
   output logic [NLANES-1:0]      charisk_o,
   output logic [NLANES-1:0]      valid_o,
   output logic [NLANES-1:0]      lane_up,
   output logic                   all_up,
   output logic [16*NLANES-1:0]   err_cnt,
   input  logic                   err_clr,
   input  logic [16*NLANES-1:0]   tx_data_i,
   input  logic [NLANES-1:0]      tx_valid_i,
   output logic [16*NLANES-1:0]   tx_data,
   output logic [2*NLANES-1:0]    tx_charisk
);
   logic [NLANES-1:0] is_up;
   logic              all_up_q;

   for (genvar i = 0; i < NLANES; i++) begin : g_lane
      gtplink_lane #(
         .COMMA(COMMA), .IDLE_HI(IDLE_HI), .UP_COUNT(UP_COUNT),
         .ERR_LIMIT(ERR_LIMIT), .WINDOW(WINDOW)
      ) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .err_clr_i  (err_clr),
         .rx_data_i  (rx_data[16*i +: 16]),
         .rx_k_i     (rx_charisk[2*i +: 2]),
         .rx_e_i     (rx_err[2*i +: 2]),
         .tx_data_i  (tx_data_i[16*i +: 16]),
         .tx_valid_i (tx_valid_i[i]),
         .data_o     (data_o[16*i +: 16]),
         .k_o        (charisk_o[i]),
         .valid_o    (valid_o[i]),
         .up_o       (lane_up[i]),
         .is_up_o    (is_up[i]),
         .err_cnt_o  (err_cnt[16*i +: 16]),
         .tx_data_o  (tx_data[16*i +: 16]),
         .tx_k_o     (tx_charisk[2*i +: 2])
      );
   end

   // all_up registered from the same state as lane_up so both move together
   always_ff @(posedge clk) begin
      if (!rst_n) all_up_q <= 1'b0;
      else        all_up_q <= &is_up;
   end

   assign all_up = all_up_q;
endmodule

// File: tb/tb_gtplink_n.sv
// Directed bench for gtplink_n (4 lanes, default parameters).
// Lanes 0-2 idle as {50,BC}/K=01; lane 3 idles byte-swapped {BC,50}/K=10.
module tb_gtplink_n;
   localparam int NL = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [16*NL-1:0]  rx_data, data_o, err_cnt, tx_data_i, tx_data;
   logic [2*NL-1:0]   rx_charisk, rx_err, tx_charisk;
   logic [NL-1:0]     charisk_o, valid_o, lane_up, tx_valid_i;
   logic              all_up, err_clr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      int          lane;
      logic [15:0] d;
      logic        k;
      logic        v;
   } rx_exp_t;

   typedef struct {
      string            tag;
      logic [16*NL-1:0] d;
      logic [2*NL-1:0]  k;
   } tx_exp_t;

   rx_exp_t rxq[$];
   tx_exp_t txq[$];

   gtplink_n dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_charisk(rx_charisk),
      .rx_err(rx_err), .data_o(data_o), .charisk_o(charisk_o), .valid_o(valid_o),
      .lane_up(lane_up), .all_up(all_up), .err_cnt(err_cnt), .err_clr(err_clr),
      .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_data(tx_data),
      .tx_charisk(tx_charisk)
   );

   always #4 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idles();
      for (int l = 0; l < NL; l++) begin
         rx_data[16*l +: 16]  = (l == 3) ? 16'hBC50 : 16'h50BC;
         rx_charisk[2*l +: 2] = (l == 3) ? 2'b10 : 2'b01;
      end
      rx_err = '0;
   endtask

   // Clock once, then check every expectation queued with this step's stimulus
   task automatic step();
      rx_exp_t e;
      tx_exp_t t;
      tick();
      while (rxq.size() > 0) begin
         e = rxq.pop_front();
         chk({e.tag, "_data"},  64'(data_o[16*e.lane +: 16]), 64'(e.d));
         chk({e.tag, "_k"},     64'(charisk_o[e.lane]),       64'(e.k));
         chk({e.tag, "_valid"}, 64'(valid_o[e.lane]),         64'(e.v));
      end
      while (txq.size() > 0) begin
         t = txq.pop_front();
         chk({t.tag, "_txd"}, 64'(tx_data), 64'(t.d));
         chk({t.tag, "_txk"}, 64'(tx_charisk), 64'(t.k));
      end
   endtask

   initial begin
      logic [16*NL-1:0] ed;
      logic [2*NL-1:0]  ek;

      rst_n = 1'b0; err_clr = 1'b0; tx_valid_i = '0; tx_data_i = '0;
      rx_data = '0; rx_charisk = '0; rx_err = '0;
      tick(); tick();
      chk("rst_data",   64'(data_o), 64'd0);
      chk("rst_up",     64'(lane_up), 64'd0);
      chk("rst_allup",  64'(all_up), 64'd0);
      chk("rst_errcnt", 64'(err_cnt), 64'd0);
      chk("rst_txd",    64'(tx_data), {4{16'h50BC}});
      chk("rst_txk",    64'(tx_charisk), 64'h55);

      // Bring-up: lane 3 needs one extra cycle to find its swapped comma
      rst_n = 1'b1;
      idles();
      for (int i = 1; i <= 18; i++) begin
         tick();
         chk($sformatf("bring_valid_%0d", i), 64'(valid_o), 64'd0);
         if (i == 16) chk("bring_up16", 64'(lane_up), 64'h0);
         if (i == 17) begin
            chk("bring_up17", 64'(lane_up), 64'h7);
            chk("bring_all17", 64'(all_up), 64'd0);
         end
         if (i == 18) begin
            chk("bring_up18", 64'(lane_up), 64'hF);
            chk("bring_all18", 64'(all_up), 64'd1);
         end
      end

      // Payload on lane 0 (straight) and 1234 split across words on lane 3
      rx_data[15:0] = 16'hCAFE; rx_charisk[1:0] = 2'b00;
      rx_data[63:48] = 16'h3450; rx_charisk[7:6] = 2'b00;
      rxq.push_back('{"pay0", 0, 16'hCAFE, 1'b0, 1'b1});
      rxq.push_back('{"swapA", 3, 16'h50BC, 1'b1, 1'b0});
      step();
      idles();
      rx_data[63:48] = 16'hBC12; rx_charisk[7:6] = 2'b10;
      rxq.push_back('{"idle0", 0, 16'h50BC, 1'b1, 1'b0});
      rxq.push_back('{"swapB", 3, 16'h1234, 1'b0, 1'b1});
      step();
      idles();
      rxq.push_back('{"swapC", 3, 16'h50BC, 1'b1, 1'b0});
      step();

      // Drop: four error cycles inside the first window on lane 0
      rx_err[1:0] = 2'b01;
      repeat (4) tick();
      chk("drop_up_hold", 64'(lane_up), 64'hF);
      idles();
      tick();
      chk("drop_up", 64'(lane_up), 64'hE);
      chk("drop_allup", 64'(all_up), 64'd0);
      chk("drop_errcnt", 64'(err_cnt), 64'd4);

      // Re-sync lane 0, then 3 errors / window wrap / 3 errors
      repeat (20) tick();
      chk("resync_up", 64'(lane_up), 64'hF);
      rx_err[1:0] = 2'b10;
      repeat (3) tick();
      idles();
      repeat (300) tick();
      rx_err[1:0] = 2'b01;
      repeat (3) tick();
      idles();
      repeat (2) tick();
      chk("wrap_up", 64'(lane_up), 64'hF);
      chk("wrap_errcnt", 64'(err_cnt), 64'd10);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("clr_errcnt", 64'(err_cnt), 64'd0);

      // TX: alternate valid lanes, idle words inserted elsewhere
      for (int i = 0; i < 6; i++) begin
         tx_valid_i = (i % 2 == 1) ? 4'b0101 : 4'b1010;
         for (int l = 0; l < NL; l++) begin
            tx_data_i[16*l +: 16] = 16'h1000 + 16'(i * 16 + l);
            ed[16*l +: 16] = tx_valid_i[l] ? tx_data_i[16*l +: 16] : 16'h50BC;
            ek[2*l +: 2]   = tx_valid_i[l] ? 2'b00 : 2'b01;
         end
         txq.push_back('{$sformatf("tx%0d", i), ed, ek});
         step();
      end

      // Saturation on lane 1, then clear with a simultaneous error
      rx_err[3:2] = 2'b11;
      repeat (65540) @(posedge clk);
      #1;
      chk("sat_ffff", 64'(err_cnt[31:16]), 64'hFFFF);
      repeat (3) tick();
      chk("sat_hold", 64'(err_cnt[31:16]), 64'hFFFF);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      chk("sat_clr", 64'(err_cnt[31:16]), 64'd0);
      idles();

      // Reset mid-frame with TX payload pending
      tx_valid_i = 4'hF;
      rx_data[15:0] = 16'hCAFE; rx_charisk[1:0] = 2'b00; rx_err[1:0] = 2'b01;
      rst_n = 1'b0;
      tick();
      chk("mrst_data",   64'(data_o), 64'd0);
      chk("mrst_k",      64'(charisk_o), 64'd0);
      chk("mrst_valid",  64'(valid_o), 64'd0);
      chk("mrst_up",     64'(lane_up), 64'd0);
      chk("mrst_allup",  64'(all_up), 64'd0);
      chk("mrst_errcnt", 64'(err_cnt), 64'd0);
      chk("mrst_txd",    64'(tx_data), {4{16'h50BC}});
      chk("mrst_txk",    64'(tx_charisk), 64'h55);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/gtplink_n.md
GTPLINK_N -- requirements
Module: gtplink_n

Interface
REQ-001 Parameter NLANES, default 4: number of 16-bit serial lanes handled (1..8).
REQ-002 Parameter COMMA, default 8'hBC: K28.5 comma byte used for alignment and idle.
REQ-003 Parameter IDLE_HI, default 8'h50: data byte sent in the upper half of a TX idle word.
REQ-004 Parameter UP_COUNT, default 16: number of consecutive clean commas needed to declare a lane up (2..255).
REQ-005 Parameter ERR_LIMIT, default 4: number of errors within one window that drops a lane (1..255).
REQ-006 Parameter WINDOW, default 256: error-window length in clk cycles (power of two, 16..65536).
REQ-007 clk  in  1  lane user clock (125 MHz); all logic runs on this single clock.
REQ-008 rst_n  in  1  reset, synchronous, active-low.
REQ-009 rx_data  in  16*NLANES  raw received words; lane i is bits [16i+15:16i].
REQ-010 rx_charisk  in  2*NLANES  per-byte K-character flags for rx_data.
REQ-011 rx_err  in  2*NLANES  per-byte disparity-error OR not-in-table flags.
REQ-012 data_o  out  16*NLANES  byte-aligned received words.
REQ-013 charisk_o  out  NLANES  high when either byte of the aligned word is a K-char.
REQ-014 valid_o  out  NLANES  high when the lane is up and the aligned word carries no K-char.
REQ-015 lane_up  out  NLANES  per-lane link state is UP.
REQ-016 all_up  out  1  AND of all lane_up bits.
REQ-017 err_cnt  out  16*NLANES  per-lane saturating error counter.
REQ-018 err_clr  in  1  synchronous clear of all err_cnt.
REQ-019 tx_data_i  in  16*NLANES  payload to transmit.
REQ-020 tx_valid_i  in  NLANES  the lane's payload is valid this cycle.
REQ-021 tx_data  out  16*NLANES  words for the transceiver.
REQ-022 tx_charisk  out  2*NLANES  per-byte K flags for tx_data.

Function
REQ-023 Lanes SHALL be fully independent except for all_up and err_clr.
REQ-024 Comma detection per byte: rx_charisk bit set and byte == COMMA.
REQ-025 Each lane SHALL hold a swap flag. A low-byte comma clears swap, and a high-byte comma sets it; updates occur only in the DOWN and SYNC states.
REQ-026 Alignment with swap=0: aligned word at cycle n is rx[n].
REQ-027 Alignment with swap=1: aligned word is {rx[n][7:0], rx[n-1][15:8]}, with K and error bits realigned identically.
REQ-028 data_o, charisk_o, valid_o SHALL be registered with latency 1 clk from the rx inputs.
REQ-029 An aligned error is any realigned rx_err bit set. In UP state, a comma found in the high byte of the aligned word also counts as an error.
REQ-030 Per-lane FSM states are DOWN, SYNC and UP; the reset state is DOWN.
REQ-031 DOWN: on an aligned comma in the low byte, go to SYNC and set comma_cnt=1.
REQ-032 SYNC: on any aligned error, go to DOWN. Otherwise each aligned low-byte comma increments comma_cnt. When comma_cnt reaches UP_COUNT, go to UP. Non-comma words neither increment nor reset comma_cnt.
REQ-033 UP: the window counter wraps every WINDOW cycles, and win_err is cleared at each wrap. Each error cycle increments win_err. When win_err reaches ERR_LIMIT, go to DOWN at the next clk.
REQ-034 If an error occurs on the wrap cycle, it SHALL count toward the new window (win_err=1).
REQ-035 lane_up SHALL be registered from state==UP; all_up SHALL be registered in the same cycle as lane_up.
REQ-036 err_cnt SHALL increment on each aligned-error cycle in every state and saturate at 16'hFFFF.
REQ-037 err_clr takes precedence over a simultaneous increment; the counter becomes 0.
REQ-038 TX path, registered with latency 1: when tx_valid_i is set, tx_data=tx_data_i and tx_charisk=2'b00. Otherwise tx_data={IDLE_HI, COMMA} and tx_charisk=2'b01.
REQ-039 valid_o SHALL be 0 whenever lane_up is 0, regardless of the data.

Reset
REQ-040 While rst_n=0 at a rising edge, the following outputs SHALL be 0 from the next edge: data_o, charisk_o, valid_o, lane_up, all_up, err_cnt.
REQ-041 Reset SHALL also clear swap, the previous-byte register and all counters, and set every FSM to DOWN.
REQ-042 While in reset, tx_data SHALL be {IDLE_HI, COMMA} and tx_charisk SHALL be 2'b01 on all lanes.
REQ-043 Reset asserted mid-operation SHALL take effect at the next edge, with no partial state retained.

Verification
REQ-044 Bring-up: lane 0 receives a stream of {8'h50, 8'hBC} with K=01 and no errors. Required response: lane_up[0] rises 16 commas after the first comma plus 1 register cycle; valid_o stays 0.
REQ-045 Swap: idles arrive as {8'hBC, x} with K=10, then data 16'h1234 is split across words. Required response: data_o carries the realigned word with 1 cycle latency and valid_o=1 once the lane is up.
REQ-046 Drop: the lane is up and 4 error cycles are injected within 256 cycles. Required response: lane_up falls, and err_cnt=4.
REQ-047 Window wrap: the lane is up, 3 errors occur, the window wraps, then 3 more errors occur. Required response: lane_up stays 1.
REQ-048 Saturation and clear: err_cnt is forced to FFFF and errors continue. Required response: err_cnt holds at FFFF. Then err_clr is asserted together with an error. Required response: err_cnt=0.
REQ-049 TX and reset: tx_valid_i toggles. Required response: tx_data alternates between payload and {50,BC} with K=01. Then rst_n is pulled low mid-frame. Required response: all lanes go DOWN and outputs are 0 at the next edge.
